// File: rtl/act_unit.sv
// act_unit: two-stage valid/ready activation stage (bypass / ReLU / leaky / clipped ReLU).
// Optional per-frame statistics outputs are enabled by defining ACT_UNIT_STATS_EN.
module act_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_BITS  = 4,
  parameter int CH_NUM     = 128,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   cfg_mode,
  input  logic [DATA_WIDTH-1:0]        cfg_clip,
  input  logic                         fin_start,
  input  logic                         din_vld,
  output logic                         din_rdy,
  input  logic [CH_NUM*DATA_WIDTH-1:0] din,
  output logic                         fout_start,
  output logic                         dout_vld,
  input  logic                         dout_rdy,
  output logic [CH_NUM*DATA_WIDTH-1:0] dout
`ifdef ACT_UNIT_STATS_EN
  ,
  output logic                         stat_vld,
  output logic [31:0]                  stat_beats,
  output logic [31:0]                  stat_clip_beats
`endif
);

  generate
    if (LEAK_SHIFT < 1 || LEAK_SHIFT >= DATA_WIDTH || FRAC_BITS >= DATA_WIDTH) begin : g_bad_param
      $error("act_unit: illegal LEAK_SHIFT or FRAC_BITS");
    end
  endgenerate

  logic                         w_adv1, w_adv2, w_accept, w_emit;
  logic [1:0]                   w_act_mode;
  logic [DATA_WIDTH-1:0]        w_act_clip;
  logic [CH_NUM*DATA_WIDTH-1:0] w_res;

  logic                         r_rdy_en;
  logic [1:0]                   r_mode;
  logic [DATA_WIDTH-1:0]        r_clip;
  logic                         r_s1_vld, r_s1_start;
  logic [1:0]                   r_s1_mode;
  logic [DATA_WIDTH-1:0]        r_s1_clip;
  logic [CH_NUM*DATA_WIDTH-1:0] r_s1_data;
  logic                         r_s2_vld, r_s2_start;
  logic [CH_NUM*DATA_WIDTH-1:0] r_s2_data;

  assign w_adv2   = ~r_s2_vld | dout_rdy;
  assign w_adv1   = ~r_s1_vld | w_adv2;
  // r_rdy_en keeps din_rdy low during reset and for the first edge after release
  assign din_rdy  = w_adv1 & r_rdy_en;
  assign w_accept = din_vld & din_rdy;
  assign w_emit   = r_s2_vld & dout_rdy;

  assign w_act_mode = fin_start ? cfg_mode : r_mode;
  assign w_act_clip = fin_start ? cfg_clip : r_clip;

  assign dout_vld   = r_s2_vld;
  assign fout_start = r_s2_start;
  assign dout       = r_s2_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdy_en   <= 1'b0;
      r_mode     <= 2'd0;
      r_clip     <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_start <= 1'b0;
      r_s1_mode  <= 2'd0;
      r_s1_clip  <= '0;
      r_s1_data  <= '0;
      r_s2_vld   <= 1'b0;
      r_s2_start <= 1'b0;
      r_s2_data  <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_accept && fin_start) begin
        r_mode <= cfg_mode;
        r_clip <= cfg_clip;
      end
      if (w_adv1) begin
        r_s1_vld <= w_accept;
        if (w_accept) begin
          r_s1_start <= fin_start;
          r_s1_mode  <= w_act_mode;
          r_s1_clip  <= w_act_clip;
          r_s1_data  <= din;
        end
      end
      if (w_adv2) begin
        r_s2_vld   <= r_s1_vld;
        r_s2_start <= r_s1_vld & r_s1_start;
        if (r_s1_vld) begin
          r_s2_data <= w_res;
        end
      end
    end
  end

`ifdef ACT_UNIT_STATS_EN
  logic [CH_NUM-1:0] w_chg_ch;
`endif

  generate
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
      logic signed [DATA_WIDTH-1:0] w_x, w_c, w_y;
      assign w_x = r_s1_data[gi*DATA_WIDTH +: DATA_WIDTH];
      // a negative clip bound clamps everything to zero
      assign w_c = r_s1_clip[DATA_WIDTH-1] ? '0 : r_s1_clip;
      always_comb begin
        w_y = w_x;
        case (r_s1_mode)
          2'd1: if (w_x[DATA_WIDTH-1]) w_y = '0;
          2'd2: if (w_x[DATA_WIDTH-1]) w_y = w_x >>> LEAK_SHIFT;
          2'd3: begin
            if (w_x[DATA_WIDTH-1])  w_y = '0;
            else if (w_x > w_c)     w_y = w_c;
          end
          default: w_y = w_x;
        endcase
      end
      assign w_res[gi*DATA_WIDTH +: DATA_WIDTH] = w_y;
`ifdef ACT_UNIT_STATS_EN
      assign w_chg_ch[gi] = (w_y != w_x);
`endif
    end
  endgenerate

`ifdef ACT_UNIT_STATS_EN
  logic        r_s2_chg, r_have_prev, r_stat_vld;
  logic [31:0] r_beats, r_clip_cnt, r_stat_beats, r_stat_clip;

  assign stat_vld        = r_stat_vld;
  assign stat_beats      = r_stat_beats;
  assign stat_clip_beats = r_stat_clip;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_chg     <= 1'b0;
      r_have_prev  <= 1'b0;
      r_beats      <= '0;
      r_clip_cnt   <= '0;
      r_stat_vld   <= 1'b0;
      r_stat_beats <= '0;
      r_stat_clip  <= '0;
    end else begin
      r_stat_vld <= 1'b0;
      if (w_adv2 && r_s1_vld) begin
        r_s2_chg <= |w_chg_ch;
      end
      if (w_emit) begin
        if (r_s2_start) begin
          // publish the finished frame and restart counting with this beat
          r_stat_vld  <= r_have_prev;
          if (r_have_prev) begin
            r_stat_beats <= r_beats;
            r_stat_clip  <= r_clip_cnt;
          end
          r_have_prev <= 1'b1;
          r_beats     <= 32'd1;
          r_clip_cnt  <= {31'd0, r_s2_chg};
        end else begin
          r_beats    <= r_beats + 32'd1;
          r_clip_cnt <= r_clip_cnt + {31'd0, r_s2_chg};
        end
      end
    end
  end
`endif

endmodule

// File: doc/act_unit.md
Name: act_unit

Overview:
- Parametrised activation stage for the nnFPGA datapath; successor to the single-mode ReLU.
- Applies a per-frame selectable activation (bypass, ReLU, leaky ReLU, clipped ReLU) to CH_NUM signed fixed-point channels per beat.
- Sits between accumulator/requant output and the next layer's input buffer.
- Adds a valid/ready handshake so downstream backpressure stalls the pipeline without data loss.

Parameters:
- DATA_WIDTH, 8, bits per channel, signed two's complement.
- FRAC_BITS, 4, fractional bits; informational only, no arithmetic depends on it.
- CH_NUM, 128, channels per beat.
- LEAK_SHIFT, 3, leaky slope = 2^-LEAK_SHIFT; legal range 1..DATA_WIDTH-1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- cfg_mode  in  2  0 = bypass, 1 = ReLU, 2 = leaky ReLU, 3 = clipped ReLU.
- cfg_clip  in  DATA_WIDTH  signed upper clamp for mode 3.
- fin_start  in  1  first beat of frame, qualified by din_vld.
- din_vld  in  1  input beat valid.
- din_rdy  out  1  block accepts input this cycle.
- din  in  CH_NUM*DATA_WIDTH  signed input channels; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- fout_start  out  1  first output beat of frame, qualified by dout_vld.
- dout_vld  out  1  output beat valid.
- dout_rdy  in  1  downstream accepts output.
- dout  out  CH_NUM*DATA_WIDTH  activated channels.

Behaviour:
- Reset: dout_vld, fout_start, dout, internal valids, latched mode and latched clip all go to 0.
  - Latched mode therefore resets to bypass.
  - din_rdy reflects the empty pipeline and is 1 one cycle after reset deasserts; it is 0 while reset is high.
- Accept: a beat is accepted when din_vld & din_rdy.
- Emit: a beat is emitted when dout_vld & dout_rdy.
- Pipeline: two register stages, S1 then S2 (output).
  - S1 captures din, fin_start and the active mode/clip.
  - S2 holds the computed result.
  - Latency from accept to dout_vld is 2 cycles when unstalled.
  - Throughput is 1 beat/clk.
- Flow control:
  - adv2 = ~s2_vld | dout_rdy.
  - adv1 = ~s1_vld | adv2.
  - din_rdy = adv1.
  - No bubbles are inserted. A stalled S2 holds dout, dout_vld and fout_start stable.
- Mode latch:
  - On an accepted beat with fin_start = 1, cfg_mode and cfg_clip are sampled. These values apply to that beat and to every following beat until the next accepted fin_start.
  - cfg changes mid-frame are ignored.
  - Beats accepted before any fin_start use bypass.
- Arithmetic, per channel, with x signed DATA_WIDTH:
  - bypass: y = x.
  - ReLU: y = x < 0 ? 0 : x.
  - leaky: y = x < 0 ? (x >>> LEAK_SHIFT) : x. Arithmetic shift rounds toward -inf, so -1 maps to -1.
  - clipped: c = (cfg_clip < 0) ? 0 : cfg_clip; y = x < 0 ? 0 : (x > c ? c : x).
  - No result exceeds DATA_WIDTH bits, so no saturation logic is needed beyond the clamp.
- fout_start travels with its beat through S1 and S2.
- Back-to-back fin_start: each accepted fin_start beat re-latches cfg, including consecutive cycles.
- Simultaneous accept into S1 and emit from S2: both occur in the same cycle with no loss.
- Reset mid-operation: in-flight beats are discarded. No partial output.

Optional Feature:
- Macro ACT_UNIT_STATS_EN.
- When defined, the block adds these outputs:
  - stat_vld (1).
  - stat_beats (32).
  - stat_clip_beats (32).
- Counter operation:
  - Counters increment on each emitted beat.
  - stat_clip_beats increments when any channel of that beat was changed by the activation: negative zeroed, shifted, or clamped.
  - Both counters are 32-bit wrapping.
- Frame boundary:
  - When a beat with fout_start is emitted and a previous frame exists, stat_vld pulses 1 cycle with the previous frame's totals.
  - Counters restart at 1 (or 0/1 for clip) for the new frame in that same cycle.
- Reset clears counters, stat outputs, and the "previous frame exists" flag.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan (DATA_WIDTH = 8, CH_NUM = 4, LEAK_SHIFT = 3):
- ReLU frame:
  - Stimulus: mode = 1, fin_start beat din = {0xF0, 0x10, 0x00, 0x80}, dout_rdy = 1.
  - Response: dout = {0x00, 0x10, 0x00, 0x00} exactly 2 cycles later with fout_start = 1.
- Leaky:
  - Stimulus: mode = 2, din = {0xF0, 0xFF, 0x7F, 0x80}.
  - Response: dout = {0xFE, 0xFF, 0x7F, 0xF0}.
- Clipped:
  - Stimulus: mode = 3, cfg_clip = 0x60, din = {0x70, 0x50, 0xC0, 0x60}.
  - Response: {0x60, 0x50, 0x00, 0x60}.
  - Repeat with cfg_clip = 0xF0: all outputs 0x00.
- Mid-frame cfg change:
  - Stimulus: start a frame in mode 1, switch cfg_mode to 0 on beat 2 without fin_start, din = 0xF0.
  - Response: output 0x00.
  - Next fin_start beat in mode 0: output 0xF0.
- Backpressure:
  - Stimulus: stream 8 beats with din_vld = 1; dout_rdy toggles 1,0,0,1,...
  - Response: all 8 beats emerge in order, unduplicated; din_rdy = 0 only while both stages are full and dout_rdy = 0; dout is stable during stalls.
- Reset mid-stream:
  - Stimulus: assert reset with 2 beats in flight.
  - Response: dout_vld = 0 immediately (asynchronous). After release, a new frame produces correct output and the latched mode was bypass before that frame's fin_start.
  - With ACT_UNIT_STATS_EN: 3-beat frame, then fin_start → stat_vld = 1, stat_beats = 3.
